// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the word-serial adder:
//   WORD_W     width of one adder slice word
//   MAX_WORDS  largest supported operand size in words
//   state_e    controller states of seq_adder64
//   word_sel   extracts 16-bit word idx from a (zero-extended) wide vector
// ----------------------------------------------------------------------------
package adder_pkg;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned MAX_WORDS = 8;
   localparam int unsigned MAX_W     = WORD_W * MAX_WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Callers zero-extend narrower operands to MAX_W before selecting.
   function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_W-1:0] vec,
                                                  input int unsigned      idx);
      return vec[idx*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/seq_adder64_if.sv
// ----------------------------------------------------------------------------
// seq_adder64_if
// Request/result bundle of seq_adder64.
//   start, a, b, cin          request side (driven by the master)
//   busy, done, sum, cout, ovf result side (driven by the adder)
// Modports: master (requester), slave (adder).
// ----------------------------------------------------------------------------
interface seq_adder64_if #(
   parameter int unsigned WORDS = 4
) ();

   localparam int unsigned OP_W = adder_pkg::WORD_W * WORDS;

   logic            start;
   logic [OP_W-1:0] a;
   logic [OP_W-1:0] b;
   logic            cin;
   logic            busy;
   logic            done;
   logic [OP_W-1:0] sum;
   logic            cout;
   logic            ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a_i, b_i  addend bits
//   ci_i      carry in
//   s_o       sum bit
//   co_o      carry out
// ----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   logic p;

   assign p    = a_i ^ b_i;
   assign s_o  = p ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

// File: rtl/rca16_cin.sv
// ----------------------------------------------------------------------------
// rca16_cin
// 16-bit ripple-carry adder slice with carry in, built from full_adder cells.
//   a, b  16-bit addends
//   ci    carry in
//   f     {carry out, 16-bit sum}
// ----------------------------------------------------------------------------
module rca16_cin
   import adder_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              ci,
   output logic [WORD_W:0]   f
);

   logic [WORD_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      full_adder u_fa (
         .a_i  (a[i]),
         .b_i  (b[i]),
         .ci_i (c[i]),
         .s_o  (f[i]),
         .co_o (c[i+1])
      );
   end

   assign f[WORD_W] = c[WORD_W];

endmodule

// File: rtl/seq_adder64.sv
// ----------------------------------------------------------------------------
// seq_adder64
// Word-serial wide adder. Operands are captured on an accepted start, then
// one 16-bit word per cycle is pushed through a single rca16_cin slice with
// the carry chained through carry_q. Result, carry out and signed overflow
// are registered and held until the next accepted start.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_adder64_if slave: start/a/b/cin in, busy/done/sum/cout/ovf out
// Parameter WORDS: words per operand, legal range 2..8.
// ----------------------------------------------------------------------------
module seq_adder64
   import adder_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_adder64_if.slave  bus
);

   localparam int unsigned OP_W  = WORD_W * WORDS;
   localparam int unsigned IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [OP_W-1:0]  sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [MAX_W-1:0]  a_ext, b_ext;
   logic [WORD_W-1:0] slice_a, slice_b;
   logic [WORD_W:0]   slice_f;

   // Word select for the current index.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      a_ext[OP_W-1:0] = a_q;
      b_ext[OP_W-1:0] = b_q;
      slice_a = word_sel(a_ext, 32'(idx_q));
      slice_b = word_sel(b_ext, 32'(idx_q));
   end

   rca16_cin u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .f  (slice_f)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end

         RUN: begin
            sum_d[WORD_W*int'(idx_q) +: WORD_W] = slice_f[WORD_W-1:0];
            carry_d = slice_f[WORD_W];
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_f[WORD_W];
               // Signed overflow: like-signed operands giving an opposite-signed sum.
               ovf_d   = (a_q[OP_W-1] == b_q[OP_W-1]) &&
                         (slice_f[WORD_W-1] != a_q[OP_W-1]);
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder64.sv
// ----------------------------------------------------------------------------
// tb_seq_adder64
// Self-checking bench for seq_adder64 with WORDS = 4.
// ----------------------------------------------------------------------------
module tb_seq_adder64;
   import adder_pkg::*;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = WORD_W * WORDS;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_adder64_if #(.WORDS(WORDS)) bus ();

   seq_adder64 #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %b required %b", name, act, req);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] s, input logic co, input logic ov);
      vec_t v;
      v.a    = a;
      v.b    = b;
      v.cin  = cin;
      v.sum  = s;
      v.cout = co;
      v.ovf  = ov;
      return v;
   endfunction

   // Scoreboard: every done pulse pops and compares one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual done=1 required no pulse");
         end else begin
            e = sb_q.pop_front();
            chk("sum", bus.sum, e.sum);
            chk1("cout", bus.cout, e.cout);
            chk1("ovf", bus.ovf, e.ovf);
         end
      end
   end

   // Called at a negedge with the DUT idle. Ports are scrambled after capture.
   task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                         input exp_t e, input string tag);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_cyc = -1;
      sb_q.push_back(e);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_;
      bus.cin   = tcin;
      for (int cyc = 1; cyc <= WORDS + 3; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            bus.start = 1'b0;
            bus.a     = ~ta;
            bus.b     = ~tb_;
            bus.cin   = ~tcin;
         end
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
      chk_i({tag, " done_count"}, done_cnt, 1);
      chk_i({tag, " done_latency"}, done_cyc, WORDS + 1);
      chk_i({tag, " busy_cycles"}, busy_cnt, WORDS + 1);
      chk({tag, " sum_held"}, bus.sum, e.sum);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: actual no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t         e;
      logic [W-1:0] ra, rb, sa, sb;
      logic         rc;
      logic [W:0]   full;
      int           busy_cnt, done_cnt, done_cyc;

      vecs.push_back(mk(64'd1000, 64'd2000, 1'b0, 64'd3000, 1'b0, 1'b0));
      vecs.push_back(mk(64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                        64'h0000_0000_0001_0000, 1'b0, 1'b0));
      vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0));
      vecs.push_back(mk(64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0));
      vecs.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                        64'h8000_0000_0000_0000, 1'b0, 1'b1));
      vecs.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                        64'd0, 1'b1, 1'b1));
      vecs.push_back(mk(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                        64'h2222_2222_2222_2212, 1'b0, 1'b0));
      vecs.push_back(mk(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0,
                        64'h0001_0000_0000_FFFF, 1'b1, 1'b0));

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;

      // Reset state.
      @(negedge clk);
      chk1("reset busy", bus.busy, 1'b0);
      chk1("reset done", bus.done, 1'b0);
      chk("reset sum", bus.sum, '0);
      chk1("reset cout", bus.cout, 1'b0);
      chk1("reset ovf", bus.ovf, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table.
      foreach (vecs[i]) begin
         e.sum  = vecs[i].sum;
         e.cout = vecs[i].cout;
         e.ovf  = vecs[i].ovf;
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, e, $sformatf("vec%0d", i));
      end

      // Random operands against a full-width behavioural add.
      for (int i = 0; i < 6; i++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         e.sum  = full[W-1:0];
         e.cout = full[W];
         e.ovf  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
         do_add(ra, rb, rc, e, $sformatf("rnd%0d", i));
      end

      // Start held high and operands changed while busy, through the done cycle.
      sa = 64'h0123_4567_89AB_CDEF;
      sb = 64'h1111_1111_1111_1111;
      e.sum  = 64'h1234_5678_9ABC_DF00;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      sb_q.push_back(e);
      bus.start = 1'b1;
      bus.a     = sa;
      bus.b     = sb;
      bus.cin   = 1'b0;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      for (int cyc = 1; cyc <= WORDS + 6; cyc++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc <= WORDS + 1) begin
            bus.start = 1'b1;
            bus.a     = {$urandom, $urandom};
            bus.b     = {$urandom, $urandom};
            bus.cin   = 1'($urandom_range(0, 1));
         end else begin
            bus.start = 1'b0;
         end
      end
      chk_i("busy_start done_count", done_cnt, 1);
      chk_i("busy_start done_latency", done_cyc, WORDS + 1);
      chk_i("busy_start busy_cycles", busy_cnt, WORDS + 1);

      // Reset two cycles into RUN.
      bus.start = 1'b1;
      bus.a     = 64'hAAAA_AAAA_AAAA_AAAA;
      bus.b     = 64'h1111_1111_1111_1111;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("midrun busy", bus.busy, 1'b0);
      chk1("midrun done", bus.done, 1'b0);
      chk("midrun sum", bus.sum, '0);
      chk1("midrun cout", bus.cout, 1'b0);
      chk1("midrun ovf", bus.ovf, 1'b0);
      done_cnt = 0;
      busy_cnt = 0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 2) rst_n = 1'b1;
         if (bus.done === 1'b1) done_cnt++;
         if (bus.busy === 1'b1) busy_cnt++;
      end
      chk_i("midrun no_done", done_cnt, 0);
      chk_i("midrun idle_after", busy_cnt, 0);

      e.sum  = 64'hFFFF_FFFF_0001_0000;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      do_add(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_0000_FFFF, 1'b0, e, "after_reset");

      chk_i("scoreboard empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
